// File: rtl/vga_pkg.sv
// Shared colour indices and the default-palette constant function for the VGA mixer.
package vga_pkg;

  localparam int BLACK = 0;
  localparam int GREEN = 1;
  localparam int RED   = 2;
  localparam int WHITE = 3;

  // Per-channel {r,g,b} on/off mask of the reset palette; entries above WHITE are black.
  function automatic logic [2:0] default_mask(int unsigned idx);
    case (idx)
      GREEN:   return 3'b010;
      RED:     return 3'b100;
      WHITE:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/vga_palette_ram.sv
// Palette registers with per-entry blink flags, one write port, one async read port.
// Blink flags exist only when VGA_MIXER_BLINK_EN is defined.
module vga_palette_ram
  import vga_pkg::*;
#(
  parameter int COLOR_BITS = 10,
  parameter int IDX_BITS   = 2
) (
  input  logic                    clock_25,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [IDX_BITS-1:0]     wr_idx,
  input  logic [3*COLOR_BITS-1:0] wr_rgb,
  input  logic                    wr_blink,
  input  logic [IDX_BITS-1:0]     rd_idx,
  output logic [3*COLOR_BITS-1:0] rd_rgb,
  output logic                    rd_blink
);

  localparam int DEPTH = 2**IDX_BITS;
  localparam int W     = 3*COLOR_BITS;

  logic [DEPTH-1:0][W-1:0] mem;

  function automatic logic [W-1:0] dflt(int unsigned idx);
    logic [2:0] m;
    m = default_mask(idx);
    return {{COLOR_BITS{m[2]}}, {COLOR_BITS{m[1]}}, {COLOR_BITS{m[0]}}};
  endfunction

  always_ff @(posedge clock_25) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= dflt(i);
    end else if (wr_en) begin
      mem[wr_idx] <= wr_rgb;
    end
  end

  assign rd_rgb = mem[rd_idx];

`ifdef VGA_MIXER_BLINK_EN
  logic [DEPTH-1:0] blink;

  always_ff @(posedge clock_25) begin
    if (reset)      blink <= '0;
    else if (wr_en) blink[wr_idx] <= wr_blink;
  end

  assign rd_blink = blink[rd_idx];
`else
  logic unused_wr_blink;
  assign unused_wr_blink = wr_blink;
  assign rd_blink        = 1'b0;
`endif

endmodule

// File: rtl/vga_layer_mixer.sv
// Two-stage VGA layer mixer: stage 1 picks the layer and reads the palette, stage 2 blinks/blanks.
// Optional blinking is built when VGA_MIXER_BLINK_EN is defined.
module vga_layer_mixer
  import vga_pkg::*;
#(
  parameter int COLOR_BITS   = 10,
  parameter int IDX_BITS     = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                    clock_25,
  input  logic                    reset,
  input  logic                    display_area,
  input  logic                    datarom,
  input  logic                    game_enable,
  input  logic [IDX_BITS-1:0]     color_data,
  input  logic                    score_time_enable,
  input  logic                    frame_start,
  input  logic                    pal_wr_valid,
  input  logic [IDX_BITS-1:0]     pal_wr_idx,
  input  logic [3*COLOR_BITS-1:0] pal_wr_rgb,
  input  logic                    pal_wr_blink,
  output logic                    pal_wr_ready,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue
);

  typedef logic [2:0][COLOR_BITS-1:0] rgb_t;

  typedef struct packed {
    logic da;
    logic blink;
    rgb_t rgb;
  } pix_t;

  logic                    pal_wr_en;
  logic [IDX_BITS-1:0]     rd_idx;
  logic [3*COLOR_BITS-1:0] pal_rgb;
  logic                    pal_blink;
  pix_t                    s1_d, s1_q;
  rgb_t                    out_q;
  logic                    blink_mask;

  assign pal_wr_ready = ~display_area & ~reset;
  assign pal_wr_en    = pal_wr_valid & pal_wr_ready;

  // Score/timer pixels always use entry 1, so the single read port is shared.
  assign rd_idx = game_enable ? color_data : IDX_BITS'(GREEN);

  vga_palette_ram #(
    .COLOR_BITS (COLOR_BITS),
    .IDX_BITS   (IDX_BITS)
  ) u_pal (
    .clock_25 (clock_25),
    .reset    (reset),
    .wr_en    (pal_wr_en),
    .wr_idx   (pal_wr_idx),
    .wr_rgb   (pal_wr_rgb),
    .wr_blink (pal_wr_blink),
    .rd_idx   (rd_idx),
    .rd_rgb   (pal_rgb),
    .rd_blink (pal_blink)
  );

  always_comb begin
    s1_d    = '0;
    s1_d.da = display_area;
    if (display_area) begin
      if (datarom) begin
        s1_d.rgb = '1;
      end else if (game_enable || score_time_enable) begin
        s1_d.rgb   = rgb_t'(pal_rgb);
        s1_d.blink = pal_blink;
      end
    end
  end

  always_ff @(posedge clock_25) begin
    if (reset) s1_q <= '0;
    else       s1_q <= s1_d;
  end

`ifdef VGA_MIXER_BLINK_EN
  logic [7:0] frame_cnt;
  logic       blink_phase;

  always_ff @(posedge clock_25) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == 8'(BLINK_FRAMES-1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt   <= frame_cnt + 8'd1;
      end
    end
  end

  assign blink_mask = s1_q.blink & blink_phase;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign blink_mask         = 1'b0;
`endif

  // Blanking uses the staged display_area so it lines up with its own pixel.
  always_ff @(posedge clock_25) begin
    if (reset)                        out_q <= '0;
    else if (s1_q.da && !blink_mask)  out_q <= s1_q.rgb;
    else                              out_q <= '0;
  end

  assign red   = out_q[2];
  assign green = out_q[1];
  assign blue  = out_q[0];

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer with hand-computed colours.
module tb_vga_layer_mixer;

  localparam int CB = 10;
  localparam int IB = 2;

  logic            clock_25 = 1'b0;
  logic            reset;
  logic            display_area, datarom, game_enable, score_time_enable, frame_start;
  logic [IB-1:0]   color_data;
  logic            pal_wr_valid;
  logic [IB-1:0]   pal_wr_idx;
  logic [3*CB-1:0] pal_wr_rgb;
  logic            pal_wr_blink;
  logic            pal_wr_ready;
  logic [CB-1:0]   red, green, blue;

  int total = 0;
  int bad   = 0;

  localparam logic [CB-1:0] ONES = '1;

  vga_layer_mixer #(
    .COLOR_BITS   (CB),
    .IDX_BITS     (IB),
    .BLINK_FRAMES (2)
  ) dut (
    .clock_25          (clock_25),
    .reset             (reset),
    .display_area      (display_area),
    .datarom           (datarom),
    .game_enable       (game_enable),
    .color_data        (color_data),
    .score_time_enable (score_time_enable),
    .frame_start       (frame_start),
    .pal_wr_valid      (pal_wr_valid),
    .pal_wr_idx        (pal_wr_idx),
    .pal_wr_rgb        (pal_wr_rgb),
    .pal_wr_blink      (pal_wr_blink),
    .pal_wr_ready      (pal_wr_ready),
    .red               (red),
    .green             (green),
    .blue              (blue)
  );

  always #20 clock_25 = ~clock_25;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rgb(input logic [CB-1:0] r, input logic [CB-1:0] g,
                                      input logic [CB-1:0] b);
    return {2'b00, r, g, b};
  endfunction

  function automatic logic [31:0] obs();
    return {2'b00, red, green, blue};
  endfunction

  task automatic pix(input logic da, input logic dr, input logic ge,
                     input logic [IB-1:0] cd, input logic st);
    display_area      = da;
    datarom           = dr;
    game_enable       = ge;
    color_data        = cd;
    score_time_enable = st;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock_25);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0;
    pal_wr_valid = 1'b0; pal_wr_idx = '0; pal_wr_rgb = '0; pal_wr_blink = 1'b0;
    pix(0, 0, 0, 0, 0);
    step(2);
    chk("reset_rgb", obs(), 32'd0);
    chk("ready_in_reset", {31'd0, pal_wr_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_idle", {31'd0, pal_wr_ready}, 32'd1);

    // Game red, plus a check that one edge is not yet enough.
    pix(1, 0, 1, 2, 0);
    step(1);
    chk("latency_1cyc", obs(), 32'd0);
    step(1);
    chk("game_red", obs(), rgb(ONES, 0, 0));

    pix(1, 0, 0, 0, 1); step(2);
    chk("score_green", obs(), rgb(0, ONES, 0));
    pix(1, 0, 1, 3, 0); step(2);
    chk("game_white", obs(), rgb(ONES, ONES, ONES));
    pix(1, 0, 1, 0, 0); step(2);
    chk("game_black", obs(), 32'd0);
    pix(1, 1, 1, 1, 0); step(2);
    chk("datarom_prio", obs(), rgb(ONES, ONES, ONES));
    pix(0, 1, 0, 0, 0); step(2);
    chk("blank_datarom", obs(), 32'd0);

    // Blanking must follow its own pixel through the pipe.
    pix(1, 0, 1, 2, 0); step(1);
    pix(0, 0, 1, 2, 0); step(1);
    chk("align_vis", obs(), rgb(ONES, 0, 0));
    step(1);
    chk("align_blank", obs(), 32'd0);

    // Write blocked while visible, accepted in blanking.
    pix(1, 0, 1, 3, 0);
    pal_wr_valid = 1'b1; pal_wr_idx = 2'd3;
    pal_wr_rgb = {10'd100, 10'd200, 10'd300};
    #1;
    chk("ready_visible", {31'd0, pal_wr_ready}, 32'd0);
    step(2);
    chk("pal_unchanged", obs(), rgb(ONES, ONES, ONES));
    display_area = 1'b0;
    #1;
    chk("ready_blank", {31'd0, pal_wr_ready}, 32'd1);
    step(1);
    pal_wr_valid = 1'b0;
    pix(1, 0, 1, 3, 0); step(2);
    chk("pal_written", obs(), rgb(10'd100, 10'd200, 10'd300));

    // Mid-line reset: outputs clear, write dropped, defaults reload.
    pix(1, 0, 1, 2, 0); step(2);
    chk("pre_reset_red", obs(), rgb(ONES, 0, 0));
    reset = 1'b1;
    display_area = 1'b0;
    pal_wr_valid = 1'b1; pal_wr_idx = 2'd0; pal_wr_rgb = {10'd1, 10'd2, 10'd3};
    #1;
    chk("ready_reset", {31'd0, pal_wr_ready}, 32'd0);
    step(1);
    chk("reset_out_black", obs(), 32'd0);
    reset = 1'b0; pal_wr_valid = 1'b0;
    pix(1, 0, 1, 0, 0); step(2);
    chk("reset_wr_dropped", obs(), 32'd0);
    pix(1, 0, 1, 3, 0); step(2);
    chk("reset_defaults", obs(), rgb(ONES, ONES, ONES));

`ifdef VGA_MIXER_BLINK_EN
    // Entry 1 green with blink set; frame 0 begins at reset release.
    pix(0, 0, 0, 0, 0);
    pal_wr_valid = 1'b1; pal_wr_idx = 2'd1;
    pal_wr_rgb = {10'd0, ONES, 10'd0}; pal_wr_blink = 1'b1;
    step(1);
    pal_wr_valid = 1'b0; pal_wr_blink = 1'b0;
    pix(1, 0, 0, 0, 1); step(2);
    chk("blink_f0", obs(), rgb(0, ONES, 0));
    frame_pulse(); step(2);
    chk("blink_f1", obs(), rgb(0, ONES, 0));
    frame_pulse(); step(2);
    chk("blink_f2", obs(), 32'd0);
    pix(1, 1, 0, 0, 0); step(2);
    chk("blink_white_kept", obs(), rgb(ONES, ONES, ONES));
    pix(1, 0, 1, 2, 0); step(2);
    chk("blink_noflag_red", obs(), rgb(ONES, 0, 0));
    pix(1, 0, 0, 0, 1);
    frame_pulse(); step(2);
    chk("blink_f3", obs(), 32'd0);
    frame_pulse(); step(2);
    chk("blink_f4", obs(), rgb(0, ONES, 0));
    frame_pulse(); step(2);
    chk("blink_f5", obs(), rgb(0, ONES, 0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
